// File: rtl/sample_interp_pkg.sv
// Shared constants and state type for the sample interpolator.
// Fixed-point layout: accumulator carries FRAC_EXTRA fraction bits below the sample.
package sample_interp_pkg;
  localparam int FRAC_EXTRA   = 7;
  localparam int RESET_SAMPLE = 'h8000;

  typedef enum logic {
    HOLD = 1'b0,
    RAMP = 1'b1
  } interp_state_t;
endpackage

// File: rtl/sample_interpolator_fifo.sv
// sample_fifo: power-of-two sample buffer, level-tracked; pop data is the head (no read latency).
// Pushes while full are dropped; wr_ready is !full and ignores a same-cycle pop.
module sample_fifo #(
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_BITS   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_en,
  output logic                 wr_ready,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [LVL_BITS-1:0]  level,
  output logic                 empty
);
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic                 push;
  logic                 pop;

  assign wr_ready = (level != LVL_BITS'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign push     = wr_en && wr_ready;
  assign pop      = rd_en && !empty;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_BITS'(1);
        2'b01:   level <= level - LVL_BITS'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/sample_interpolator.sv
// Buffers samples and ramps u16_out toward each one over 2^shift steps (SAMPLE_INTERP_LINEAR_EN),
// or jumps per step (zero-order hold) when the macro is undefined. Output moves only on step.
module sample_interpolator
  import sample_interp_pkg::*;
#(
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_BITS = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_BITS-1:0]            wr_data,
  input  logic                            wr_en,
  output logic                            wr_ready,
  input  logic                            step,
  input  logic [SHIFT_BITS-1:0]           interp_shift,
  input  logic                            clear_underrun,
  output logic [DATA_BITS-1:0]            u16_out,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            underrun
);
  localparam int ACC_BITS = DATA_BITS + FRAC_EXTRA;
  localparam int LVL_BITS = $clog2(FIFO_DEPTH) + 1;

  interp_state_t         state;
  logic [ACC_BITS-1:0]   acc;
  logic [DATA_BITS-1:0]  target;
  logic [DATA_BITS-1:0]  head;
  logic                  started;
  logic                  fifo_empty;
  logic                  pop;
  logic                  last_step;

  assign u16_out = acc[ACC_BITS-1 -: DATA_BITS];

  sample_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_BITS   (LVL_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .rd_en    (pop),
    .rd_data  (head),
    .level    (fifo_level),
    .empty    (fifo_empty)
  );

`ifdef SAMPLE_INTERP_LINEAR_EN
  logic [SHIFT_BITS-1:0]   shift_q;
  logic [FRAC_EXTRA-1:0]   count_q;
  logic signed [DATA_BITS:0] delta_q;
  logic [ACC_BITS-1:0]     ramp_inc;
  logic [ACC_BITS-1:0]     ramp_sum;
  logic [FRAC_EXTRA:0]     span_m1;

  assign span_m1   = ((FRAC_EXTRA+1)'(1) << shift_q) - (FRAC_EXTRA+1)'(1);
  assign last_step = ({1'b0, count_q} == span_m1);
  // Sign-extended delta scaled so 2^shift increments cover exactly one sample interval.
  assign ramp_inc  = ACC_BITS'(delta_q) << (SHIFT_BITS'(FRAC_EXTRA) - shift_q);
  assign ramp_sum  = acc + ramp_inc;
`else
  logic unused_cfg;
  assign unused_cfg = ^{interp_shift, acc[FRAC_EXTRA-1:0]};
  assign last_step  = 1'b1;
`endif

  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == HOLD)           pop = 1'b1;
      else if (step && last_step)  pop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HOLD;
      acc      <= ACC_BITS'(RESET_SAMPLE) << FRAC_EXTRA;
      target   <= DATA_BITS'(RESET_SAMPLE);
      started  <= 1'b0;
      underrun <= 1'b0;
`ifdef SAMPLE_INTERP_LINEAR_EN
      shift_q  <= '0;
      count_q  <= '0;
      delta_q  <= '0;
`endif
    end else begin
      if (step && state == HOLD && started) underrun <= 1'b1;
      else if (clear_underrun)              underrun <= 1'b0;

      if (pop) started <= 1'b1;

      case (state)
        HOLD: begin
          if (pop) begin
            state  <= RAMP;
            target <= head;
`ifdef SAMPLE_INTERP_LINEAR_EN
            shift_q <= interp_shift;
            count_q <= '0;
            delta_q <= $signed({1'b0, head}) - $signed({1'b0, u16_out});
`endif
          end
        end
        RAMP: begin
          if (step) begin
            if (last_step) begin
              // Snap removes any rounding residue before chaining to the next sample.
              acc <= {target, {FRAC_EXTRA{1'b0}}};
              if (pop) begin
                target <= head;
`ifdef SAMPLE_INTERP_LINEAR_EN
                shift_q <= interp_shift;
                count_q <= '0;
                delta_q <= $signed({1'b0, head}) - $signed({1'b0, target});
`endif
              end else begin
                state <= HOLD;
              end
            end
`ifdef SAMPLE_INTERP_LINEAR_EN
            else begin
              acc     <= ramp_sum;
              count_q <= count_q + FRAC_EXTRA'(1);
            end
`endif
          end
        end
        default: state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_interpolator.sv
// Self-checking bench: directed steps plus random traffic against a queue-based output model.
module tb_sample_interpolator;
  localparam int DB = 16;
  localparam int FD = 4;
  localparam int SB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DB-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          wr_ready;
  logic          step = 1'b0;
  logic [SB-1:0] interp_shift = '0;
  logic          clear_underrun = 1'b0;
  logic [DB-1:0] u16_out;
  logic [$clog2(FD):0] fifo_level;
  logic          underrun;

  int checks = 0;
  int errors = 0;

  // Reference model: output value, queued samples, pending ramp outputs.
  int cur;
  int und;
  bit started_m;
  int mq[$];
  int rq[$];

  sample_interpolator #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .SHIFT_BITS(SB)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
    .step(step), .interp_shift(interp_shift), .clear_underrun(clear_underrun),
    .u16_out(u16_out), .fifo_level(fifo_level), .underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit linear();
`ifdef SAMPLE_INTERP_LINEAR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = 'h8000;
    und = 0;
    started_m = 0;
    mq.delete();
    rq.delete();
  endtask

  // Outputs seen on each step while moving from cur to t: floor of the straight line, last = t.
  task automatic load_ramp(input int t, input int s);
    int n;
    n = linear() ? (1 << s) : 1;
    for (int k = 1; k < n; k++) rq.push_back((cur * 128 + k * (t - cur) * 128 / n) / 128);
    rq.push_back(t);
    started_m = 1;
  endtask

  task automatic model_edge(input bit we, input int wd, input bit st, input bit clr, input int sh);
    bit accept;
    accept = we && (mq.size() < FD);
    if (rq.size() == 0) begin
      if (st && started_m) und = 1;
      else if (clr) und = 0;
      if (mq.size() > 0) load_ramp(mq.pop_front(), sh);
    end else begin
      if (clr) und = 0;
      if (st) begin
        cur = rq.pop_front();
        if (rq.size() == 0 && mq.size() > 0) load_ramp(mq.pop_front(), sh);
      end
    end
    if (accept) mq.push_back(wd);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".u16_out"},    32'(u16_out),    32'(cur));
    chk({tag, ".fifo_level"}, 32'(fifo_level), 32'(mq.size()));
    chk({tag, ".wr_ready"},   32'(wr_ready),   32'(mq.size() < FD));
    chk({tag, ".underrun"},   32'(underrun),   32'(und));
  endtask

  task automatic tick(input string tag, input bit we, input int wd, input bit st,
                      input bit clr, input int sh);
    wr_en = we;
    wr_data = 16'(wd);
    step = st;
    clear_underrun = clr;
    interp_shift = 3'(sh);
    @(posedge clk);
    model_edge(we, wd, st, clr, sh);
    #1;
    wr_en = 1'b0;
    step = 1'b0;
    clear_underrun = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    int vals[4];
    int seen_dropped;
    int n;
    model_reset();

    // Reset state, asserted away from a clock edge.
    #2 reset = 1'b1;
    #2 chk_all("reset");
    @(negedge clk) reset = 1'b0;

    // Ramp to 0x9000 at shift 2.
    tick("push9000", 1, 'h9000, 0, 0, 2);
    tick("pop9000", 0, 0, 0, 0, 2);
    n = linear() ? 4 : 1;
    for (int i = 0; i < n; i++) tick("ramp9000", 0, 0, 1, 0, 2);
    chk("ramp9000.final", 32'(u16_out), 32'h9000);

    // Underrun after drain: set wins over clear, output held, then lone clear.
    tick("underrun_set", 0, 0, 1, 1, 2);
    chk("underrun_set.flag", 32'(underrun), 32'd1);
    chk("underrun_set.hold", 32'(u16_out), 32'h9000);
    tick("underrun_clr", 0, 0, 0, 1, 2);
    chk("underrun_clr.flag", 32'(underrun), 32'd0);

    // Overfill while ramping: fifth push dropped and never reaches the output.
    tick("fill_a", 1, $urandom_range(0, 'h3FFF), 0, 0, 1);
    tick("fill_pop", 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom_range(0, 'h3FFF);
      tick("fill", 1, vals[i], 0, 0, 1);
    end
    tick("fill_drop", 1, 'hF0F0, 0, 0, 1);
    chk("full.level", 32'(fifo_level), 32'd4);
    chk("full.ready", 32'(wr_ready), 32'd0);
    seen_dropped = 0;
    for (int i = 0; i < 100 && (rq.size() > 0 || mq.size() > 0); i++) begin
      tick("drain", 0, 0, 1, 0, 1);
      if (u16_out == 16'hF0F0) seen_dropped++;
    end
    chk("drain.last", 32'(u16_out), 32'(vals[3]));
    chk("drain.dropped_seen", 32'(seen_dropped), 32'd0);
    tick("drain_clr", 0, 0, 0, 1, 1);

    // Zero-order at shift 0 across full scale.
    tick("zoh_p1", 1, 'hFFFF, 0, 0, 0);
    tick("zoh_p2", 1, 'h0000, 0, 0, 0);
    tick("zoh_pop", 0, 0, 0, 0, 0);
    tick("zoh_s1", 0, 0, 1, 0, 0);
    chk("zoh_s1.val", 32'(u16_out), 32'hFFFF);
    tick("zoh_s2", 0, 0, 1, 0, 0);
    chk("zoh_s2.val", 32'(u16_out), 32'h0000);

    // Floor behaviour on one-LSB moves at shift 1.
    tick("lsb_p1", 1, 'h0001, 0, 0, 1);
    tick("lsb_p2", 1, 'h0000, 0, 0, 1);
    tick("lsb_pop", 0, 0, 0, 0, 1);
    while (rq.size() > 0 || mq.size() > 0) tick("lsb_step", 0, 0, 1, 0, 1);
    chk("lsb.final", 32'(u16_out), 32'h0000);

    // Full-scale swings at the finest ramp, no accumulator wrap.
    tick("fs_p1", 1, 'hFFFF, 0, 0, 3);
    tick("fs_p2", 1, 'h0000, 0, 0, 3);
    tick("fs_p3", 1, 'hFFFF, 0, 0, 3);
    for (int i = 0; i < 40 && (rq.size() > 0 || mq.size() > 0); i++)
      tick("fs_step", 0, 0, 1, 0, 3);
    chk("fs.final", 32'(u16_out), 32'hFFFF);

    // Asynchronous reset mid-ramp with samples still queued.
    tick("mid_p1", 1, 'h1000, 0, 0, 3);
    tick("mid_p2", 1, 'h2000, 0, 0, 3);
    tick("mid_p3", 1, 'h3000, 0, 0, 3);
    tick("mid_step", 0, 0, 1, 0, 3);
    #2 reset = 1'b1;
    model_reset();
    #1 chk_all("mid_reset");
    chk("mid_reset.u16", 32'(u16_out), 32'h8000);
    @(negedge clk) reset = 1'b0;
    tick("post_reset_step", 0, 0, 1, 0, 3);

    // Random traffic, shift changes landing mid-ramp.
    for (int i = 0; i < 600; i++) begin
      tick("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 'hFFFF),
           $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
